// File: rtl/md_pkg.sv
// md_pkg: shared opcode constants and FSM state type for the multiply/divide unit
package md_pkg;
  localparam logic [2:0] MD_NOP  = 3'd0;
  localparam logic [2:0] MD_MUL  = 3'd1;
  localparam logic [2:0] MD_DIV  = 3'd2;
  localparam logic [2:0] MD_MTHI = 3'd3;
  localparam logic [2:0] MD_MTLO = 3'd4;
  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV} type_MD_STATE;
endpackage

// File: rtl/md_unit_if.sv
// md_unit_if: EX-stage request/response bundle between the pipeline and the MD unit
interface md_unit_if;
  logic        start;
  logic [2:0]  MDFunc;
  logic        MDSign;
  logic [31:0] A;
  logic [31:0] B;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [31:0] HI;
  logic [31:0] LO;
  modport master (output start, MDFunc, MDSign, A, B, cancel, input busy, done, HI, LO);
  modport slave  (input start, MDFunc, MDSign, A, B, cancel, output busy, done, HI, LO);
endinterface

// File: rtl/md_compute.sv
// md_compute: combinational 64-bit multiply or divide result for one MD op
module md_compute
  import md_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_sign,
  input  logic [2:0]  i_op,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);
  logic        w_neg_a;
  logic        w_neg_b;
  logic        w_neg_q;
  logic [63:0] w_prod;
  logic [31:0] w_ua;
  logic [31:0] w_ub;
  logic [31:0] w_div;
  logic [31:0] w_q;
  logic [31:0] w_r;
  // Sign-magnitude divide and sign-extended multiply; a zero divisor is steered to 1 so the divider never sees 0
  always_comb begin
    w_neg_a = i_sign & i_a[31];
    w_neg_b = i_sign & i_b[31];
    w_neg_q = w_neg_a ^ w_neg_b;
    w_prod  = {{32{w_neg_a}}, i_a} * {{32{w_neg_b}}, i_b};
    w_ua    = w_neg_a ? -i_a : i_a;
    w_ub    = w_neg_b ? -i_b : i_b;
    w_div   = (i_b == 32'd0) ? 32'd1 : w_ub;
    w_q     = w_ua / w_div;
    w_r     = w_ua % w_div;
    o_hi    = (i_op == MD_MUL) ? w_prod[63:32] :
              (i_op != MD_DIV) ? 32'd0 :
              (i_b == 32'd0)   ? i_a :
              w_neg_a          ? -w_r : w_r;
    o_lo    = (i_op == MD_MUL) ? w_prod[31:0] :
              (i_op != MD_DIV) ? 32'd0 :
              (i_b == 32'd0)   ? 32'hFFFF_FFFF :
              w_neg_q          ? -w_q : w_q;
  end
endmodule

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit owning the architectural HI/LO registers
module md_unit
  import md_pkg::*;
#(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10,
  parameter int CNT_W      = 4
) (
  input logic clk,
  input logic reset,
  md_unit_if.slave bus
);
  localparam logic [CNT_W-1:0] L_MUL_N = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_DIV_N = CNT_W'(DIV_CYCLES - 1);
  type_MD_STATE     r_state;
  type_MD_STATE     w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [31:0]      r_pend_hi;
  logic [31:0]      r_pend_lo;
  logic             r_done;
  logic             w_idle;
  logic             w_accept;
  logic             w_ld;
  logic             w_mthi;
  logic             w_mtlo;
  logic             w_commit;
  logic [31:0]      w_res_hi;
  logic [31:0]      w_res_lo;

  md_compute u_compute (
    .i_a   (bus.A),
    .i_b   (bus.B),
    .i_sign(bus.MDSign),
    .i_op  (bus.MDFunc),
    .o_hi  (w_res_hi),
    .o_lo  (w_res_lo)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next state: cancel wins, IDLE launches MUL/DIV, busy states return to IDLE when the count expires
  always_comb begin
    w_next = r_state;
    if (bus.cancel) w_next = ST_IDLE;
    else if (r_state == ST_IDLE) w_next = !bus.start ? ST_IDLE :
                                          (bus.MDFunc == MD_MUL) ? ST_MUL :
                                          (bus.MDFunc == MD_DIV) ? ST_DIV : ST_IDLE;
    else if (r_cnt == '0) w_next = ST_IDLE;
  end

  // Control decode: start is only honoured in IDLE, so anything arriving while busy is dropped
  always_comb begin
    w_idle   = (r_state == ST_IDLE);
    w_accept = w_idle & bus.start & ~bus.cancel;
    w_ld     = w_accept & ((bus.MDFunc == MD_MUL) | (bus.MDFunc == MD_DIV));
    w_mthi   = w_accept & (bus.MDFunc == MD_MTHI);
    w_mtlo   = w_accept & (bus.MDFunc == MD_MTLO);
    w_commit = ~w_idle & (r_cnt == '0) & ~bus.cancel;
  end

  // Counter, pending result, done pulse and HI/LO; HI/LO only change on commit or MTHI/MTLO
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done    <= w_commit;
      r_cnt     <= bus.cancel ? '0 :
                   w_ld ? ((bus.MDFunc == MD_MUL) ? L_MUL_N : L_DIV_N) :
                   (!w_idle && r_cnt != '0) ? r_cnt - 1'b1 : r_cnt;
      r_pend_hi <= w_ld ? w_res_hi : r_pend_hi;
      r_pend_lo <= w_ld ? w_res_lo : r_pend_lo;
      r_hi      <= w_commit ? r_pend_hi : w_mthi ? bus.A : r_hi;
      r_lo      <= w_commit ? r_pend_lo : w_mtlo ? bus.A : r_lo;
    end
  end

  assign bus.busy = ~w_idle;
  assign bus.done = r_done;
  assign bus.HI   = r_hi;
  assign bus.LO   = r_lo;
endmodule
